tmds_word_aligner: RTL and testbench

Receive-side counterpart of the HDMI TMDS 10:1 output serializer. It runs in the 2x-pixel clock domain of one TMDS channel and takes 5-bit parallel beats from a 1:5 input deserializer. It gearboxes them into 10-bit symbols and finds the symbol boundary by bit-slipping until TMDS control tokens appear consistently. It then delivers aligned words, with control-token decode and a lock flag, to the downstream TMDS decoder.

---
 rtl/tmds_pkg.sv | 39 +++
 rtl/tmds_gearbox_5to10.sv | 78 +++++++
 rtl/tmds_word_aligner.sv | 175 +++++++++++++++++
 tb/tb_tmds_word_aligner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Purpose : shared TMDS control-token constants, aligner state enum and token decode.
// Latency : n/a (types, constants and a pure combinational function).
// Backpr. : n/a.
//
// The encoder side reuses TMDS_CTRL_* so both directions agree on token values.
package tmds_pkg;

    // Control tokens, bit 0 is the first bit on the wire.
    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] ctrl;
    } ctrl_dec_t;

    // Returns {is_ctrl, ctrl}; any non-token word decodes to all zeros.
    function automatic ctrl_dec_t tmds_ctrl_decode(input logic [9:0] word);
        ctrl_dec_t dec;
        dec = '0;
        case (word)
            TMDS_CTRL_00: dec = '{is_ctrl: 1'b1, ctrl: 2'b00};
            TMDS_CTRL_01: dec = '{is_ctrl: 1'b1, ctrl: 2'b01};
            TMDS_CTRL_10: dec = '{is_ctrl: 1'b1, ctrl: 2'b10};
            TMDS_CTRL_11: dec = '{is_ctrl: 1'b1, ctrl: 2'b11};
            default:      dec = '0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/tmds_gearbox_5to10.sv
// Purpose : 5-bit beat to 10-bit symbol gearbox with selectable bit offset and token decode.
// Latency : symbol whose last beat is sampled at edge n is on word at edge n+1.
// Backpr. : none; free-running, one word every other cycle.
//
// Ports:
//   clk, rst        : 2x pixel clock, async active-high reset
//   din[4:0]        : deserialized beat, din[0] earliest bit
//   offset[3:0]     : window offset 0..9 from the aligner
//   word[9:0]       : aligned symbol, word[0] earliest bit
//   word_vld        : one-cycle strobe on alternate cycles
//   is_ctrl, ctrl   : token decode of word, qualified by word_vld
module tmds_gearbox_5to10 (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] din,
    input  logic [3:0] offset,
    output logic [9:0] word,
    output logic       word_vld,
    output logic       is_ctrl,
    output logic [1:0] ctrl
);
    import tmds_pkg::*;

    logic [19:0] hist_q, hist_d;
    logic        phase_q, phase_d;
    logic [9:0]  word_q, word_d;
    logic        word_vld_q, word_vld_d;
    logic        is_ctrl_q, is_ctrl_d;
    logic [1:0]  ctrl_q, ctrl_d;

    logic [9:0]  window;
    ctrl_dec_t   dec;

    always_comb begin
        // Newest beat enters at the top, so hist_q[0] is the oldest bit held.
        hist_d  = {din, hist_q[19:5]};
        phase_d = ~phase_q;

        // offset is kept in 0..9 by the aligner, so the window never leaves hist_q.
        window = hist_q[5'd19 - {1'b0, offset} -: 10];
        dec    = tmds_ctrl_decode(window);

        word_d     = word_q;
        is_ctrl_d  = is_ctrl_q;
        ctrl_d     = ctrl_q;
        word_vld_d = 1'b0;
        if (!phase_q) begin
            word_d     = window;
            is_ctrl_d  = dec.is_ctrl;
            ctrl_d     = dec.ctrl;
            word_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q     <= '0;
            phase_q    <= 1'b0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            is_ctrl_q  <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            hist_q     <= hist_d;
            phase_q    <= phase_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            is_ctrl_q  <= is_ctrl_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign word     = word_q;
    assign word_vld = word_vld_q;
    assign is_ctrl  = is_ctrl_q;
    assign ctrl     = ctrl_q;

endmodule

// File: rtl/tmds_word_aligner.sv
// Purpose : TMDS receive word aligner; bit-slips until control tokens repeat, then reports lock.
// Latency : Word one edge after its last beat; Locked one cycle after the deciding word.
// Backpr. : none; downstream must accept every WordValid strobe and qualify on Locked.
//
// Ports:
//   Clk, Reset         : 2x pixel clock, async active-high reset
//   Din[4:0]           : deserialized beat, Din[0] earliest bit
//   Resync             : one-cycle request to drop alignment and slip by one bit
//   Word[9:0]          : aligned symbol (not gated by Locked)
//   WordValid          : strobe on alternate cycles
//   IsCtrl, Ctrl[1:0]  : control-token decode of Word
//   Locked             : alignment established
//   Offset[3:0]        : current slip offset 0..9
module tmds_word_aligner #(
    parameter int SEARCH_WORDS = 4096,
    parameter int RUN_LEN      = 8,
    parameter int LOSS_WORDS   = 65536
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] Din,
    input  logic       Resync,
    output logic [9:0] Word,
    output logic       WordValid,
    output logic       IsCtrl,
    output logic [1:0] Ctrl,
    output logic       Locked,
    output logic [3:0] Offset
);
    import tmds_pkg::*;

    localparam int WC_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
    localparam int RC_W = (RUN_LEN > 1)      ? $clog2(RUN_LEN)      : 1;
    localparam int LC_W = (LOSS_WORDS > 1)   ? $clog2(LOSS_WORDS)   : 1;

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(SEARCH_WORDS - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RUN_LEN - 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOSS_WORDS - 1);

    align_state_t    state_q, state_d;
    logic [3:0]      offset_q, offset_d;
    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic [RC_W-1:0] run_cnt_q, run_cnt_d;
    logic [LC_W-1:0] loss_cnt_q, loss_cnt_d;
    logic            locked_q, locked_d;

    logic [9:0]      word_w;
    logic            word_vld_w;
    logic            is_ctrl_w;
    logic [1:0]      ctrl_w;

    logic [3:0]      offset_inc;
    logic            word_cnt_last;
    logic [WC_W-1:0] word_cnt_sat;

    tmds_gearbox_5to10 u_gearbox (
        .clk      (Clk),
        .rst      (Reset),
        .din      (Din),
        .offset   (offset_q),
        .word     (word_w),
        .word_vld (word_vld_w),
        .is_ctrl  (is_ctrl_w),
        .ctrl     (ctrl_w)
    );

    always_comb begin
        // A 10-bit slip is the same alignment one word later, so wrap without
        // touching the gearbox phase.
        offset_inc    = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        word_cnt_last = (word_cnt_q == WC_LAST);
        // Search-window expiry only fires on non-token words; a token landing
        // on the last count holds the counter there instead of wrapping, so the
        // next non-token word slips.
        word_cnt_sat  = word_cnt_last ? word_cnt_q : word_cnt_q + WC_W'(1);

        state_d    = state_q;
        offset_d   = offset_q;
        word_cnt_d = word_cnt_q;
        run_cnt_d  = run_cnt_q;
        loss_cnt_d = loss_cnt_q;

        if (Resync) begin
            // Overrides whatever the current word would have done.
            state_d    = SEARCH;
            offset_d   = offset_inc;
            word_cnt_d = '0;
            run_cnt_d  = '0;
            loss_cnt_d = '0;
        end else if (word_vld_w) begin
            case (state_q)
                SEARCH: begin
                    if (is_ctrl_w) begin
                        state_d    = CHECK;
                        run_cnt_d  = RC_W'(1);
                        word_cnt_d = word_cnt_sat;
                    end else if (word_cnt_last) begin
                        offset_d   = offset_inc;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
                CHECK: begin
                    if (is_ctrl_w) begin
                        if (run_cnt_q == RC_LAST) begin
                            state_d    = LOCKED;
                            run_cnt_d  = '0;
                            word_cnt_d = '0;
                            loss_cnt_d = '0;
                        end else begin
                            run_cnt_d  = run_cnt_q + RC_W'(1);
                            word_cnt_d = word_cnt_sat;
                        end
                    end else begin
                        // Broken run: keep the offset unless the window expired.
                        state_d   = SEARCH;
                        run_cnt_d = '0;
                        if (word_cnt_last) begin
                            offset_d   = offset_inc;
                            word_cnt_d = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (is_ctrl_w) begin
                        loss_cnt_d = '0;
                    end else if (loss_cnt_q == LC_LAST) begin
                        state_d    = SEARCH;
                        word_cnt_d = '0;
                        loss_cnt_d = '0;
                    end else begin
                        loss_cnt_d = loss_cnt_q + LC_W'(1);
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    word_cnt_d = '0;
                    run_cnt_d  = '0;
                    loss_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= SEARCH;
            offset_q   <= '0;
            word_cnt_q <= '0;
            run_cnt_q  <= '0;
            loss_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            word_cnt_q <= word_cnt_d;
            run_cnt_q  <= run_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign Word      = word_w;
    assign WordValid = word_vld_w;
    assign IsCtrl    = is_ctrl_w;
    assign Ctrl      = ctrl_w;
    assign Locked    = locked_q;
    assign Offset    = offset_q;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner with SEARCH_WORDS=16, RUN_LEN=8, LOSS_WORDS=64.
// Beat c (counted from the first edge after reset release) is sampled at edge c;
// the word loaded at edge 2m covers stream bits 10m-10-Offset .. 10m-1-Offset.
module tb_tmds_word_aligner;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b0;
    logic       Resync = 1'b0;
    logic [4:0] Din    = '0;
    logic [9:0] Word;
    logic       WordValid;
    logic       IsCtrl;
    logic [1:0] Ctrl;
    logic       Locked;
    logic [3:0] Offset;

    tmds_word_aligner #(
        .SEARCH_WORDS (16),
        .RUN_LEN      (8),
        .LOSS_WORDS   (64)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Din       (Din),
        .Resync    (Resync),
        .Word      (Word),
        .WordValid (WordValid),
        .IsCtrl    (IsCtrl),
        .Ctrl      (Ctrl),
        .Locked    (Locked),
        .Offset    (Offset)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fails  = 0;
    int n_edges  = 0;

    // Stream model: skew leading zero bits, then symbols; symbols with index
    // in [dat_lo, dat_hi) carry dat_w, all others carry tok_w.
    logic [9:0] tok_w  = 10'h354;
    logic [9:0] dat_w  = 10'h1F0;
    int         skew   = 0;
    int         dat_lo = 0;
    int         dat_hi = 0;

    function automatic logic [4:0] beat(input int c);
        logic [4:0] b;
        logic [9:0] s;
        int t;
        int k;
        int j;
        b = '0;
        for (int i = 0; i < 5; i++) begin
            t = 5 * c + i;
            if (t >= skew) begin
                k = (t - skew) / 10;
                j = (t - skew) % 10;
                s = (k >= dat_lo && k < dat_hi) ? dat_w : tok_w;
                b[i] = s[j];
            end
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        n_edges++;
        #1;
        Din    = beat(n_edges);
        Resync = 1'b0;
    endtask

    task automatic tick_to(input int n);
        while (n_edges < n) tick();
    endtask

    // Asserts reset between edges, checks the immediate clear, loads a new
    // stream and releases reset on a falling edge.
    task automatic do_reset(input string tag, input logic [9:0] tok, input int sk,
                            input int lo, input int hi);
        Reset = 1'b1;
        #1;
        chk({tag, "_word"},   Word,      16'h000);
        chk({tag, "_wvld"},   WordValid, 16'h0);
        chk({tag, "_isctrl"}, IsCtrl,    16'h0);
        chk({tag, "_ctrl"},   Ctrl,      16'h0);
        chk({tag, "_locked"}, Locked,    16'h0);
        chk({tag, "_offset"}, Offset,    16'h0);
        tok_w  = tok;
        skew   = sk;
        dat_lo = lo;
        dat_hi = hi;
        Din    = beat(0);
        Resync = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset   = 1'b0;
        n_edges = 0;
    endtask

    initial begin
        // ---- T1: 0x354 at skew 0, lock after 8 tokens at offset 0 ----
        do_reset("rst1", 10'h354, 0, 1000, 1000);
        tick();
        chk("t1_first_wvld", WordValid, 16'h1);
        chk("t1_first_word", Word, 16'h000);
        tick();
        chk("t1_second_wvld", WordValid, 16'h0);
        for (int m = 1; m <= 8; m++) begin
            tick_to(2 * m + 1);
            chk("t1_wvld", WordValid, 16'h1);
            chk("t1_word", Word, 16'h354);
            chk("t1_isctrl", IsCtrl, 16'h1);
            chk("t1_ctrl", Ctrl, 16'h0);
        end
        chk("t1_not_yet_locked", Locked, 16'h0);
        tick();
        chk("t1_locked", Locked, 16'h1);
        chk("t1_offset", Offset, 16'h0);

        // ---- T4: Resync steps to offset 4, lock at skew 6, Resync on a token ----
        do_reset("rst4", 10'h354, 6, 1000, 1000);
        for (int i = 0; i < 4; i++) begin
            Resync = 1'b1;
            tick();
        end
        chk("t4_offset_after_resync", Offset, 16'h4);
        chk("t4_unlocked", Locked, 16'h0);
        tick_to(19);
        chk("t4_not_yet_locked", Locked, 16'h0);
        tick_to(20);
        chk("t4_locked", Locked, 16'h1);
        chk("t4_offset_locked", Offset, 16'h4);
        tick();
        chk("t4_tok_wvld", WordValid, 16'h1);
        chk("t4_tok_word", Word, 16'h354);
        Resync = 1'b1;
        tick();
        chk("t4_resync_locked", Locked, 16'h0);
        chk("t4_resync_offset", Offset, 16'h5);
        tick_to(24);
        chk("t4_stays_unlocked", Locked, 16'h0);
        chk("t4_offset_held", Offset, 16'h5);

        // ---- T5: run of 5 tokens broken by one data word, relock after 8 more ----
        do_reset("rst5", 10'h354, 0, 5, 6);
        tick_to(13);
        chk("t5_data_word", Word, 16'h1F0);
        chk("t5_data_isctrl", IsCtrl, 16'h0);
        tick_to(14);
        chk("t5_after_break_locked", Locked, 16'h0);
        chk("t5_after_break_offset", Offset, 16'h0);
        tick_to(28);
        chk("t5_seven_tokens_locked", Locked, 16'h0);
        tick_to(30);
        chk("t5_relocked", Locked, 16'h1);
        chk("t5_offset", Offset, 16'h0);

        // ---- T3: lock, then data 0x1F0 from symbol 10; loss on 64th data word ----
        do_reset("rst3", 10'h354, 0, 10, 110);
        tick_to(18);
        chk("t3_locked", Locked, 16'h1);
        tick_to(147);
        chk("t3_data_word", Word, 16'h1F0);
        chk("t3_data_isctrl", IsCtrl, 16'h0);
        chk("t3_data_ctrl", Ctrl, 16'h0);
        tick_to(148);
        chk("t3_loss63_locked", Locked, 16'h1);
        tick_to(150);
        chk("t3_loss64_locked", Locked, 16'h0);
        chk("t3_offset_kept", Offset, 16'h0);

        // ---- T2: 0x2AB skewed by 3 bits, search must slip to offset 7 ----
        do_reset("rst2", 10'h2AB, 3, 1000, 1000);
        while (Locked !== 1'b1 && n_edges < 2 * (10 * 16 + 8) + 2) tick();
        chk("t2_locked", Locked, 16'h1);
        chk("t2_offset", Offset, 16'h7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wvld", WordValid, 16'h1);
            chk("t2_word", Word, 16'h2AB);
            chk("t2_ctrl", Ctrl, 16'h3);
            chk("t2_isctrl", IsCtrl, 16'h1);
            chk("t2_still_locked", Locked, 16'h1);
            tick();
            chk("t2_wvld_gap", WordValid, 16'h0);
        end

        // ---- T6: reset mid-CHECK, then WordValid restarts after the first edge ----
        do_reset("rst6a", 10'h354, 0, 1000, 1000);
        tick_to(7);
        chk("t6_midcheck_word", Word, 16'h354);
        chk("t6_midcheck_isctrl", IsCtrl, 16'h1);
        do_reset("t6_rst", 10'h354, 0, 1000, 1000);
        tick();
        chk("t6_wvld_e0", WordValid, 16'h1);
        chk("t6_word_e0", Word, 16'h000);
        tick();
        chk("t6_wvld_e1", WordValid, 16'h0);
        tick();
        chk("t6_wvld_e2", WordValid, 16'h1);
        chk("t6_word_e2", Word, 16'h354);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
